// File: rtl/rhythm_monitor_if.sv
// Beat-monitor bus: packet header and timestamp in, LED pins and measured interval out.
// The master side is the packet source, the slave side is the monitor.
interface rhythm_monitor_if #(
  parameter int CNT_W = 32
);
  logic [7:0]       header;
  logic [CNT_W-1:0] counter;
  logic             tachy_pin;
  logic             brady_pin;
  logic             normal_pin;
  logic             beat_valid;
  logic [CNT_W-1:0] interval;

  modport master (
    output header, counter,
    input  tachy_pin, brady_pin, normal_pin, beat_valid, interval
  );

  modport slave (
    input  header, counter,
    output tachy_pin, brady_pin, normal_pin, beat_valid, interval
  );
endinterface

// File: rtl/rhythm_monitor.sv
// Heart-rhythm monitor: measures beat-to-beat intervals from header-tagged packets,
// debounces the rate class over CONFIRM_N beats and drives steady/blinking LEDs.
module rhythm_monitor #(
  parameter int         CNT_W      = 32,
  parameter int         FAST_BEAT  = 750,
  parameter int         SLOW_BEAT  = 1800,
  parameter logic [7:0] HEAD1      = 8'd4,
  parameter logic [7:0] HEAD2      = 8'd6,
  parameter int         CONFIRM_N  = 3,
  parameter int         FLASH_HALF = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  rhythm_monitor_if.slave  bus
);

  // Class codes share the state encoding so a confirmed class maps directly onto the FSM.
  localparam logic [1:0] ST_NORMAL = 2'd0;
  localparam logic [1:0] ST_TACHY  = 2'd1;
  localparam logic [1:0] ST_BRADY  = 2'd2;

  localparam int STREAK_W = $clog2(CONFIRM_N + 1);
  localparam int BLINK_W  = $clog2(FLASH_HALF + 1);

  localparam logic [CNT_W-1:0]    FAST_TH    = CNT_W'(FAST_BEAT);
  localparam logic [CNT_W-1:0]    SLOW_TH    = CNT_W'(SLOW_BEAT);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(CONFIRM_N);
  localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(FLASH_HALF - 1);

  logic [1:0]          state_q, state_d;
  logic [1:0]          class_q, class_d;
  logic [CNT_W-1:0]    prev_q, prev_d;
  logic                primed_q, primed_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [CNT_W-1:0]    interval_q, interval_d;
  logic                beat_valid_q, beat_valid_d;

  logic             is_beat;
  logic [CNT_W-1:0] delta;
  logic [1:0]       beat_class;

  assign is_beat = (bus.header == HEAD1) || (bus.header == HEAD2);
  // Modular subtraction gives the right distance across a timestamp wrap.
  assign delta   = bus.counter - prev_q;

  always_comb begin
    if (delta <= FAST_TH) begin
      beat_class = ST_TACHY;
    end else if (delta >= SLOW_TH) begin
      beat_class = ST_BRADY;
    end else begin
      beat_class = ST_NORMAL;
    end
  end

  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    prev_d       = prev_q;
    primed_d     = primed_q;
    streak_d     = streak_q;
    interval_d   = interval_q;
    beat_valid_d = 1'b0;

    if (is_beat) begin
      prev_d   = bus.counter;
      primed_d = 1'b1;
      if (primed_q) begin
        beat_valid_d = 1'b1;
        interval_d   = delta;
        class_d      = beat_class;
        if ((streak_q == '0) || (beat_class != class_q)) begin
          streak_d = STREAK_W'(1);
        end else if (streak_q != STREAK_MAX) begin
          streak_d = streak_q + 1'b1;
        end
        if (streak_d == STREAK_MAX) begin
          state_d = beat_class;
        end
      end
    end
  end

  // Blink restarts high on any state change; a re-confirming beat leaves it running.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (state_d != state_q) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (state_q != ST_NORMAL) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_NORMAL;
      class_q      <= ST_NORMAL;
      prev_q       <= '0;
      primed_q     <= 1'b0;
      streak_q     <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      interval_q   <= '0;
      beat_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      class_q      <= class_d;
      prev_q       <= prev_d;
      primed_q     <= primed_d;
      streak_q     <= streak_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      interval_q   <= interval_d;
      beat_valid_q <= beat_valid_d;
    end
  end

  assign bus.normal_pin = (state_q == ST_NORMAL);
  assign bus.tachy_pin  = (state_q == ST_TACHY) && phase_q;
  assign bus.brady_pin  = (state_q == ST_BRADY) && phase_q;
  assign bus.beat_valid = beat_valid_q;
  assign bus.interval   = interval_q;

endmodule

// File: doc/rhythm_monitor.md
RHYTHM_MONITOR -- requirements
Module: rhythm_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 32, which sets the width of the timestamp and interval datapath.
REQ-002 SHALL have parameter FAST_BEAT, default 750, which is the tachycardia threshold: interval <= FAST_BEAT is classed fast.
REQ-003 SHALL have parameter SLOW_BEAT, default 1800, which is the bradycardia threshold: interval >= SLOW_BEAT is classed slow.
REQ-004 SHALL have parameter HEAD1, default 8'd4, which is the first header code that marks a beat.
REQ-005 SHALL have parameter HEAD2, default 8'd6, which is the second header code that marks a beat.
REQ-006 SHALL have parameter CONFIRM_N, default 3, legal range >= 1, which is the number of consecutive same-class intervals needed to change state.
REQ-007 SHALL have parameter FLASH_HALF, default 8, legal range >= 1, which is the LED blink half-period in clk cycles.
REQ-008 SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-009 SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-010 SHALL have port header, input, width 8: packet header, sampled every cycle.
REQ-011 SHALL have port counter, input, width CNT_W: free-running timestamp.
REQ-012 SHALL have port tachy_pin, output, width 1: tachycardia LED, blinking.
REQ-013 SHALL have port brady_pin, output, width 1: bradycardia LED, blinking.
REQ-014 SHALL have port normal_pin, output, width 1: normal-rhythm LED, steady.
REQ-015 SHALL have port beat_valid, output, width 1: one-cycle pulse when a new interval is measured.
REQ-016 SHALL have port interval, output, width CNT_W: the last measured interval, registered.

Function
REQ-017 SHALL treat a cycle with header == HEAD1 or header == HEAD2 as a beat; all other header values SHALL be ignored.
REQ-018 SHALL, on the first beat after reset, only capture counter into the previous-timestamp register; no classification, no beat_valid pulse, state unchanged.
REQ-019 SHALL, on each later beat, compute interval = (counter - prev) mod 2^CNT_W, so counter wrap-around yields the correct distance, and then set prev <= counter.
REQ-020 SHALL classify each interval as fast if interval <= FAST_BEAT, else slow if interval >= SLOW_BEAT, else normal; fast SHALL win if both conditions hold.
REQ-021 SHALL register interval and assert beat_valid high for exactly one cycle, in the cycle after the beat cycle.
REQ-022 SHALL keep a streak counter: +1 when the class equals the previous class, reset to 1 when the class changes, saturating at CONFIRM_N.
REQ-023 SHALL implement an FSM with states NORMAL, TACHY and BRADY, entering the state matching the current class on the beat whose updated streak equals CONFIRM_N.
REQ-024 SHALL allow direct TACHY<->BRADY transitions, and SHALL make the new state visible one cycle after the beat cycle.
REQ-025 SHALL drive normal_pin = 1 only in NORMAL, tachy_pin = 0 outside TACHY, and brady_pin = 0 outside BRADY.
REQ-026 SHALL clear the blink counter and set the blink phase to 1 on every state change; in TACHY or BRADY the active pin SHALL follow the phase, which toggles every FLASH_HALF cycles (high FLASH_HALF, low FLASH_HALF, repeating).
REQ-027 SHALL keep blinking without interruption while further beats confirm the current state.
REQ-028 SHALL take no action when no beat occurs; timestamps, state and blink SHALL continue unaffected.

Reset
REQ-029 SHALL, while rst_n = 0, asynchronously force state = NORMAL, prev = 0, the primed flag = 0, streak = 0, blink counter and phase = 0, interval = 0, beat_valid = 0, tachy_pin = 0, brady_pin = 0, normal_pin = 1.
REQ-030 SHALL treat the first beat after a reset asserted mid-operation (for example during TACHY) as a baseline per REQ-018.

Verification
REQ-031 SHALL cover: reset, then a beat at counter=1000 -> beat_valid stays 0, normal_pin=1, no state change.
REQ-032 SHALL cover: beats at 1000/1500/2000/2500 -> three beat_valid pulses with interval=500; TACHY entered one cycle after the 2500 beat; tachy_pin high 8 cycles, low 8 cycles, repeating; normal_pin=0.
REQ-033 SHALL cover: interval boundaries -> 750 is fast, 751 and 1799 are normal, 1800 is slow (CONFIRM_N=1 build).
REQ-034 SHALL cover: classes fast, fast, normal, fast -> state stays NORMAL, and the streak is 1 after the normal interval.
REQ-035 SHALL cover: prev=0xFFFFFF00, then a beat at counter=0x00000200 -> interval=0x300 (768), classed normal.
REQ-036 SHALL cover: rst_n pulsed low during BRADY -> pins go 0/0/1 immediately without waiting for clk, and the next beat produces no beat_valid.
